// File: rtl/afu_mmio_csr_router.sv
// AFU MMIO CSR front end: local DFH/ID/ERROR/SCRATCH registers plus NUM_CH downstream 32-bit CSR windows; local read data 1 cycle after accept.
// waitrequest is held high while a downstream access is in flight; AFU_MMIO_CSR_TIMEOUT_EN adds a per-access downstream timeout.
module afu_mmio_csr_router #(
    parameter logic [127:0]         AFU_ID      = 128'h0,
    parameter int                   NUM_CH      = 2,
    parameter int                   CH_ADDR_W   = 16,
    parameter logic [NUM_CH*18-1:0] CH_BASE     = {18'h00C00, 18'h00400},
    parameter logic [NUM_CH*18-1:0] CH_SPAN     = {18'h00100, 18'h00600},
    parameter int                   TIMEOUT_CYC = 1023
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [17:0]            avmm_address,
    input  logic [63:0]            avmm_writedata,
    input  logic [7:0]             avmm_byteenable,
    input  logic                   avmm_write,
    input  logic                   avmm_read,
    output logic                   avmm_waitrequest,
    output logic [63:0]            avmm_readdata,
    output logic                   avmm_readdatavalid,
    output logic [CH_ADDR_W-1:0]   ch_address,
    output logic [31:0]            ch_writedata,
    output logic [NUM_CH-1:0]      ch_write,
    output logic [NUM_CH-1:0]      ch_read,
    input  logic [NUM_CH*32-1:0]   ch_readdata,
    input  logic [NUM_CH-1:0]      ch_readdatavalid,
    input  logic [NUM_CH-1:0]      ch_waitrequest
);

    localparam int CH_IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_CH_REQ = 2'd1;
    localparam logic [1:0] S_CH_RSP = 2'd2;
    localparam logic [1:0] S_RESP   = 2'd3;

    localparam logic [17:0] A_DFH  = 18'h00000;
    localparam logic [17:0] A_IDL  = 18'h00002;
    localparam logic [17:0] A_IDH  = 18'h00004;
    localparam logic [17:0] A_RSVD = 18'h00006;
    localparam logic [17:0] A_ERR  = 18'h0000F;
    localparam logic [17:0] A_SCR  = 18'h00020;

    // DFH: feature type AFU in [63:60], end-of-list in bit 40.
    localparam logic [63:0] DFH_VAL = {4'h1, 19'h0, 1'b1, 40'h0};

    if (NUM_CH < 1 || NUM_CH > 8 || TIMEOUT_CYC < 1 || TIMEOUT_CYC > 1023) begin : g_bad_cfg
        $error("afu_mmio_csr_router: unsupported parameterisation");
    end

    logic [1:0]            r_state;
    logic [CH_IDX_W-1:0]   r_sel;
    logic                  r_op_rd;
    logic [CH_ADDR_W-1:0]  r_addr;
    logic [31:0]           r_wdata;
    logic                  r_waitreq;
    logic                  r_rdvalid;
    logic [63:0]           r_rddata;
    logic [63:0]           r_scratch;

    logic                  w_cmd;
    logic                  w_local;
    logic                  w_ch_hit;
    logic [CH_IDX_W-1:0]   w_ch_idx;
    logic [CH_ADDR_W-1:0]  w_ch_off;
    logic [63:0]           w_local_rdata;
    logic [NUM_CH-1:0]     w_error;
    logic                  w_tmo;
    logic [NUM_CH-1:0]     w_ch_read;
    logic [NUM_CH-1:0]     w_ch_write;

    assign w_cmd   = (r_state == S_IDLE) && !r_waitreq && (avmm_read || avmm_write);
    assign w_local = avmm_address inside {A_DFH, A_IDL, A_IDH, A_RSVD, A_ERR, A_SCR};

    // Scan from the top so the lowest matching window wins on overlap.
    always_comb begin
        w_ch_hit = 1'b0;
        w_ch_idx = '0;
        w_ch_off = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (({1'b0, avmm_address} >= {1'b0, CH_BASE[i*18 +: 18]}) &&
                ({1'b0, avmm_address} < ({1'b0, CH_BASE[i*18 +: 18]} + {1'b0, CH_SPAN[i*18 +: 18]}))) begin
                w_ch_hit = 1'b1;
                w_ch_idx = CH_IDX_W'(i);
                w_ch_off = CH_ADDR_W'(avmm_address - CH_BASE[i*18 +: 18]);
            end
        end
    end

    always_comb begin
        w_local_rdata = 64'h0;
        case (avmm_address)
            A_DFH:   w_local_rdata = DFH_VAL;
            A_IDL:   w_local_rdata = AFU_ID[63:0];
            A_IDH:   w_local_rdata = AFU_ID[127:64];
            A_ERR:   w_local_rdata = {{(64-NUM_CH){1'b0}}, w_error};
            A_SCR:   w_local_rdata = r_scratch;
            default: w_local_rdata = 64'h0;
        endcase
    end

`ifdef AFU_MMIO_CSR_TIMEOUT_EN
    logic [9:0]        r_tmo_cnt;
    logic [NUM_CH-1:0] r_error;

    assign w_tmo   = ((r_state == S_CH_REQ) || (r_state == S_CH_RSP)) && (r_tmo_cnt == 10'(TIMEOUT_CYC));
    assign w_error = r_error;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tmo_cnt <= '0;
        end else if (w_cmd) begin
            r_tmo_cnt <= '0;
        end else if ((r_state == S_CH_REQ) || (r_state == S_CH_RSP)) begin
            r_tmo_cnt <= r_tmo_cnt + 10'd1;
        end
    end

    // Set and clear cannot collide: clears happen only in IDLE, sets only mid-access.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_error <= '0;
        end else if (w_tmo) begin
            r_error[r_sel] <= 1'b1;
        end else if (w_cmd && avmm_write && !avmm_read && avmm_address == A_ERR) begin
            r_error <= r_error & ~avmm_writedata[NUM_CH-1:0];
        end
    end
`else
    assign w_tmo   = 1'b0;
    assign w_error = '0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_sel     <= '0;
            r_op_rd   <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_waitreq <= 1'b0;
            r_rdvalid <= 1'b0;
            r_rddata  <= '0;
            r_scratch <= '0;
        end else begin
            r_rdvalid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_cmd) begin
                        if (w_ch_hit && !w_local) begin
                            r_sel     <= w_ch_idx;
                            r_op_rd   <= avmm_read;
                            r_addr    <= w_ch_off;
                            r_wdata   <= avmm_writedata[31:0];
                            r_waitreq <= 1'b1;
                            r_state   <= S_CH_REQ;
                        end else if (avmm_read) begin
                            r_rdvalid <= 1'b1;
                            r_rddata  <= w_local_rdata;
                        end else if (avmm_address == A_SCR) begin
                            for (int b = 0; b < 8; b++) begin
                                if (avmm_byteenable[b]) begin
                                    r_scratch[b*8 +: 8] <= avmm_writedata[b*8 +: 8];
                                end
                            end
                        end
                    end
                end
                S_CH_REQ: begin
                    if (w_tmo) begin
                        if (r_op_rd) begin
                            r_rddata  <= 64'hFFFF_FFFF_FFFF_FFFF;
                            r_rdvalid <= 1'b1;
                            r_state   <= S_RESP;
                        end else begin
                            r_waitreq <= 1'b0;
                            r_state   <= S_IDLE;
                        end
                    end else if (!ch_waitrequest[r_sel]) begin
                        if (r_op_rd) begin
                            r_state   <= S_CH_RSP;
                        end else begin
                            r_waitreq <= 1'b0;
                            r_state   <= S_IDLE;
                        end
                    end
                end
                S_CH_RSP: begin
                    if (w_tmo) begin
                        r_rddata  <= 64'hFFFF_FFFF_FFFF_FFFF;
                        r_rdvalid <= 1'b1;
                        r_state   <= S_RESP;
                    end else if (ch_readdatavalid[r_sel]) begin
                        r_rddata  <= {32'h0, ch_readdata[r_sel*32 +: 32]};
                        r_rdvalid <= 1'b1;
                        r_state   <= S_RESP;
                    end
                end
                default: begin
                    r_waitreq <= 1'b0;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        w_ch_read  = '0;
        w_ch_write = '0;
        if (r_state == S_CH_REQ) begin
            if (r_op_rd) begin
                w_ch_read[r_sel] = 1'b1;
            end else begin
                w_ch_write[r_sel] = 1'b1;
            end
        end
    end

    assign avmm_waitrequest   = r_waitreq;
    assign avmm_readdata      = r_rddata;
    assign avmm_readdatavalid = r_rdvalid;
    assign ch_address         = r_addr;
    assign ch_writedata       = r_wdata;
    assign ch_read            = w_ch_read;
    assign ch_write           = w_ch_write;

endmodule

// File: tb/tb_afu_mmio_csr_router.sv
// Bench for afu_mmio_csr_router: register-map/window model, response scoreboard and a scripted downstream responder.
module tb_afu_mmio_csr_router;

    localparam int NUM_CH      = 2;
    localparam int CH_ADDR_W   = 16;
    localparam int TIMEOUT_CYC = 1023;
    localparam logic [127:0] AFU_ID_P = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    localparam logic [NUM_CH*18-1:0] CH_BASE_P = {18'h00C00, 18'h00400};
    localparam logic [NUM_CH*18-1:0] CH_SPAN_P = {18'h00100, 18'h00600};

    logic                  clk = 1'b0;
    logic                  reset = 1'b1;
    logic [17:0]           avmm_address = '0;
    logic [63:0]           avmm_writedata = '0;
    logic [7:0]            avmm_byteenable = '0;
    logic                  avmm_write = 1'b0;
    logic                  avmm_read = 1'b0;
    logic                  avmm_waitrequest;
    logic [63:0]           avmm_readdata;
    logic                  avmm_readdatavalid;
    logic [CH_ADDR_W-1:0]  ch_address;
    logic [31:0]           ch_writedata;
    logic [NUM_CH-1:0]     ch_write;
    logic [NUM_CH-1:0]     ch_read;
    logic [NUM_CH*32-1:0]  ch_readdata;
    logic [NUM_CH-1:0]     ch_readdatavalid;
    logic [NUM_CH-1:0]     ch_waitrequest;

    afu_mmio_csr_router #(
        .AFU_ID(AFU_ID_P), .NUM_CH(NUM_CH), .CH_ADDR_W(CH_ADDR_W),
        .CH_BASE(CH_BASE_P), .CH_SPAN(CH_SPAN_P), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk(clk), .reset(reset),
        .avmm_address(avmm_address), .avmm_writedata(avmm_writedata),
        .avmm_byteenable(avmm_byteenable), .avmm_write(avmm_write), .avmm_read(avmm_read),
        .avmm_waitrequest(avmm_waitrequest), .avmm_readdata(avmm_readdata),
        .avmm_readdatavalid(avmm_readdatavalid),
        .ch_address(ch_address), .ch_writedata(ch_writedata),
        .ch_write(ch_write), .ch_read(ch_read), .ch_readdata(ch_readdata),
        .ch_readdatavalid(ch_readdatavalid), .ch_waitrequest(ch_waitrequest)
    );

    initial forever #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [63:0] data;
        int          acc;
        int          lat_min;
        int          lat_max;
    } rsp_t;
    rsp_t exp_q[$];

    // Model state: register contents and the address map as plain tables.
    int          ch_base [NUM_CH] = '{32'h400, 32'hC00};
    int          ch_span [NUM_CH] = '{32'h600, 32'h100};
    logic [63:0] m_scratch = '0;
    logic [NUM_CH-1:0] m_error = '0;

    int          exp_ch = 0;
    bit          exp_rd = 1'b0;
    logic [15:0] exp_addr = '0;

    int          rsp_stall = 0;
    bit          rsp_give = 1'b1;
    bit          rsp_noise = 1'b0;
    logic [31:0] rsp_data = '0;

    logic [15:0] last_ch_addr = '0;
    logic [31:0] last_ch_wdata = '0;
    bit          seen_w0 = 1'b0;
    bit          seen_w1 = 1'b0;

    task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_rng(input string name, input int act, input int lo, input int hi);
        n_checks++;
        if (act < lo || act > hi) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    function automatic int route(input logic [17:0] a);
        if (a inside {18'h0, 18'h2, 18'h4, 18'h6, 18'hF, 18'h20}) return -1;
        for (int i = 0; i < NUM_CH; i++)
            if (int'(a) >= ch_base[i] && int'(a) < ch_base[i] + ch_span[i]) return i;
        return -1;
    endfunction

    function automatic logic [63:0] model_local(input logic [17:0] a);
        case (a)
            18'h0:   return {4'h1, 19'h0, 1'b1, 40'h0};
            18'h2:   return AFU_ID_P[63:0];
            18'h4:   return AFU_ID_P[127:64];
            18'hF:   return {{(64-NUM_CH){1'b0}}, m_error};
            18'h20:  return m_scratch;
            default: return 64'h0;
        endcase
    endfunction

    task automatic model_write(input logic [17:0] a, input logic [63:0] d, input logic [7:0] be);
        if (a == 18'h20) begin
            for (int b = 0; b < 8; b++) if (be[b]) m_scratch[b*8 +: 8] = d[b*8 +: 8];
        end
`ifdef AFU_MMIO_CSR_TIMEOUT_EN
        if (a == 18'hF) m_error = m_error & ~d[NUM_CH-1:0];
`endif
    endtask

    // Issue one command, wait for acceptance and record what the model expects.
    task automatic mmio(input bit rd, input bit wr, input logic [17:0] a, input logic [63:0] d,
                        input logic [7:0] be, input int lat_min, input int lat_max, input logic [63:0] ch_rdata);
        int   r;
        int   n;
        rsp_t e;
        r = route(a);
        if (r >= 0) begin
            exp_ch   = r;
            exp_rd   = rd;
            exp_addr = 16'(int'(a) - ch_base[r]);
        end
        @(posedge clk); #1;
        avmm_address = a; avmm_writedata = d; avmm_byteenable = be;
        avmm_read = rd; avmm_write = wr;
        n = 0;
        @(negedge clk);
        while (avmm_waitrequest && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (avmm_waitrequest) chk64("accept_timeout", 64'(avmm_waitrequest), 64'd0);
        @(posedge clk);
        if (rd) begin
            e.data = (r >= 0) ? ch_rdata : model_local(a);
            e.acc = cyc;
            e.lat_min = lat_min;
            e.lat_max = lat_max;
            exp_q.push_back(e);
        end else if (wr && r < 0) begin
            model_write(a, d, be);
        end
        #1;
        avmm_read = 1'b0;
        avmm_write = 1'b0;
    endtask

    task automatic lrd(input logic [17:0] a);
        mmio(1'b1, 1'b0, a, 64'h0, 8'hFF, 1, 1, 64'h0);
    endtask

    task automatic lwr(input logic [17:0] a, input logic [63:0] d, input logic [7:0] be);
        mmio(1'b0, 1'b1, a, d, be, 0, 0, 64'h0);
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        @(negedge clk);
        while ((exp_q.size() != 0 || avmm_waitrequest) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0 || avmm_waitrequest) begin
            chk64("idle_timeout", 64'(exp_q.size()), 64'd0);
            exp_q.delete();
        end
    endtask

    // Compare process: every response and every downstream strobe cycle.
    initial begin
        rsp_t e;
        logic [NUM_CH-1:0] m;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (avmm_readdatavalid) begin
                    if (exp_q.size() == 0) begin
                        chk64("unexpected_rdvalid", 64'd1, 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk64("readdata", avmm_readdata, e.data);
                        chk_rng("rd_latency", cyc - e.acc, e.lat_min, e.lat_max);
                    end
                end
                if ((ch_read | ch_write) != '0) begin
                    m = '0;
                    m[exp_ch] = 1'b1;
                    chk64("ch_read_mask", 64'(ch_read), exp_rd ? 64'(m) : 64'd0);
                    chk64("ch_write_mask", 64'(ch_write), exp_rd ? 64'd0 : 64'(m));
                    chk64("ch_address", 64'(ch_address), 64'(exp_addr));
                    last_ch_addr = ch_address;
                    if (ch_write[0]) seen_w0 = 1'b1;
                    if (ch_write[1]) seen_w1 = 1'b1;
                    if (ch_write != '0) last_ch_wdata = ch_writedata;
                end
            end
        end
    end

    // Downstream responder: stalls rsp_stall cycles, then returns rsp_data the cycle after the read is taken.
    initial begin
        int cnt;
        bit pend;
        cnt = 0;
        pend = 1'b0;
        ch_waitrequest = '0;
        ch_readdatavalid = '0;
        ch_readdata = '0;
        forever begin
            @(negedge clk);
            ch_readdatavalid = '0;
            if (reset) begin
                cnt = 0;
                pend = 1'b0;
                ch_waitrequest = '0;
            end else begin
                if (pend && rsp_give) begin
                    ch_readdatavalid[exp_ch] = 1'b1;
                    ch_readdata[exp_ch*32 +: 32] = rsp_data;
                end
                pend = 1'b0;
                if ((ch_read | ch_write) != '0) begin
                    if (cnt < rsp_stall) begin
                        ch_waitrequest[exp_ch] = 1'b1;
                        cnt++;
                        if (rsp_noise) begin
                            ch_readdatavalid = '1;
                            ch_readdata = {NUM_CH{32'hDEAD_BEEF}};
                        end
                    end else begin
                        ch_waitrequest[exp_ch] = 1'b0;
                        pend = ch_read[exp_ch];
                        cnt = 0;
                    end
                end else begin
                    ch_waitrequest = '0;
                    cnt = 0;
                end
            end
        end
    end

    initial begin
        bit all_hi;
        int n;

        repeat (3) @(negedge clk);
        chk64("rst_waitreq", 64'(avmm_waitrequest), 64'd0);
        chk64("rst_rdvalid", 64'(avmm_readdatavalid), 64'd0);
        chk64("rst_readdata", avmm_readdata, 64'h0);
        chk64("rst_strobes", 64'({ch_read, ch_write}), 64'd0);
        chk64("rst_ch_address", 64'(ch_address), 64'd0);
        reset = 1'b0;

        // Local registers and scratch byte enables.
        chk64("pin_dfh", model_local(18'h0), 64'h1000_0100_0000_0000);
        lrd(18'h0);
        lrd(18'h2);
        lrd(18'h4);
        lrd(18'h6);
        lwr(18'h20, 64'hA5A5_0000_1234_5678, 8'h0F);
        chk64("pin_scratch", model_local(18'h20), 64'h0000_0000_1234_5678);
        lrd(18'h20);
        lwr(18'h20, 64'hFFEE_DDCC_0000_0000, 8'hF0);
        lrd(18'h20);
        mmio(1'b1, 1'b1, 18'h20, 64'h0, 8'hFF, 1, 1, 64'h0);
        lrd(18'h20);
        chk64("pin_scratch2", model_local(18'h20), 64'hFFEE_DDCC_1234_5678);
        lrd(18'h3FF);
        lrd(18'hA00);
        lwr(18'h100, 64'h1, 8'hFF);
        wait_idle(20);
        chk64("local_no_wait", 64'(avmm_waitrequest), 64'd0);

        // Channel 0 read with 3 stall cycles and spurious readdatavalid noise.
        rsp_stall = 3; rsp_give = 1'b1; rsp_noise = 1'b1; rsp_data = 32'hCAFE_F00D;
        mmio(1'b1, 1'b0, 18'h410, 64'h0, 8'hFF, 6, 6, 64'h0000_0000_CAFE_F00D);
        chk64("pin_addr410", 64'(exp_addr), 64'h10);
        all_hi = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            all_hi &= avmm_waitrequest;
            n++;
            if (avmm_readdatavalid || n > 50) break;
        end
        chk64("waitreq_held", 64'(all_hi), 64'd1);
        chk64("ch_addr_410", 64'(last_ch_addr), 64'h0010);
        wait_idle(50);
        rsp_noise = 1'b0;

        // Minimum-latency reads, window edges.
        rsp_stall = 0; rsp_data = 32'h1111_2222;
        mmio(1'b1, 1'b0, 18'hC80, 64'h0, 8'hFF, 3, 3, 64'h0000_0000_1111_2222);
        wait_idle(50);
        rsp_data = 32'h3333_4444;
        mmio(1'b1, 1'b0, 18'h9FF, 64'h0, 8'hFF, 3, 3, 64'h0000_0000_3333_4444);
        wait_idle(50);
        chk64("ch_addr_9ff", 64'(last_ch_addr), 64'h05FF);

        // Channel 1 write.
        seen_w0 = 1'b0; seen_w1 = 1'b0;
        rsp_stall = 2;
        mmio(1'b0, 1'b1, 18'hC05, 64'h0000_0000_0000_0042, 8'hFF, 0, 0, 64'h0);
        wait_idle(50);
        chk64("wr_seen_ch1", 64'(seen_w1), 64'd1);
        chk64("wr_not_ch0", 64'(seen_w0), 64'd0);
        chk64("wr_addr", 64'(last_ch_addr), 64'h0005);
        chk64("wr_data", 64'(last_ch_wdata), 64'h42);
        rsp_stall = 0;

`ifdef AFU_MMIO_CSR_TIMEOUT_EN
        rsp_give = 1'b0;
        mmio(1'b1, 1'b0, 18'h500, 64'h0, 8'hFF, TIMEOUT_CYC, TIMEOUT_CYC + 2, 64'hFFFF_FFFF_FFFF_FFFF);
        wait_idle(TIMEOUT_CYC + 50);
        rsp_give = 1'b1;
        m_error[0] = 1'b1;
        chk64("pin_error", model_local(18'hF), 64'h1);
        lrd(18'hF);
        lwr(18'hF, 64'h1, 8'hFF);
        lrd(18'hF);
`else
        lwr(18'hF, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
        lrd(18'hF);
`endif
        wait_idle(20);

        // Reset while waiting for a downstream response.
        rsp_give = 1'b0;
        mmio(1'b1, 1'b0, 18'h410, 64'h0, 8'hFF, 3, 3, 64'h0);
        repeat (3) @(negedge clk);
        chk64("busy_in_ch_rsp", 64'(avmm_waitrequest), 64'd1);
        reset = 1'b1;
        #1;
        chk64("mid_rst_waitreq", 64'(avmm_waitrequest), 64'd0);
        chk64("mid_rst_rdvalid", 64'(avmm_readdatavalid), 64'd0);
        chk64("mid_rst_readdata", avmm_readdata, 64'h0);
        chk64("mid_rst_strobes", 64'({ch_read, ch_write}), 64'd0);
        chk64("mid_rst_ch_address", 64'(ch_address), 64'd0);
        exp_q.delete();
        m_scratch = '0;
        m_error = '0;
        rsp_give = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        lrd(18'h0);
        lrd(18'h20);
        wait_idle(20);
        chk64("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
